// File: rtl/io_sequencer_pkg.sv
// Shared definitions for the IO sequencer: FSM encoding, idle bus value
// and the layout of the 8-bit port address.
package io_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    localparam int ADDR_X_LSB   = 0;
    localparam int ADDR_Y_LSB   = 3;
    localparam int ADDR_IDX_W   = 3;
    localparam int ADDR_RSV_LSB = 6;
    localparam int ADDR_RSV_W   = 2;

    // Only addresses with the reserved top bits clear reach a device.
    function automatic logic addr_valid(input logic [7:0] a);
        return a[ADDR_RSV_LSB +: ADDR_RSV_W] == '0;
    endfunction

endpackage

// File: rtl/io_sequencer_port_decode.sv
// 3-to-8 active-low one-hot decoder with enable; all outputs high when
// disabled so no device is selected.
module io_port_decode
    import io_sequencer_pkg::*;
(
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] sel_n
);

    always_comb begin
        sel_n = OPEN_BUS;
        if (en) begin
            sel_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/io_sequencer.sv
// Single-transaction IO bus sequencer: IDLE -> SETUP -> STROBE -> HOLD,
// with a bounded device wait and address validation.
module io_sequencer
    import io_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       dir,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic [7:0] sel_x,
    output logic [7:0] sel_y,
    output logic       port_rd_n,
    output logic       port_wr_n,
    output logic [7:0] dev_dout,
    input  logic [7:0] dev_din,
    input  logic       dev_ack
);

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic       dir_q,   dir_d;
    logic [7:0] dout_q,  dout_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       err_q,   err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       sel_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Every error path forces rdata to the open-bus value, but only for IN;
    // an OUT transaction never disturbs the last read result.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    addr_d  = addr;
                    dir_d   = dir;
                    dout_d  = wdata;
                end
            end
            ST_SETUP: begin
                if (addr_valid(addr_q)) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                    err_d   = 1'b1;
                    if (!dir_q) begin
                        rdata_d = OPEN_BUS;
                    end
                end
            end
            ST_STROBE: begin
                if (dev_ack) begin
                    state_d = ST_HOLD;
                    err_d   = 1'b0;
                    if (!dir_q) begin
                        rdata_d = dev_din;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HOLD;
                        err_d   = 1'b1;
                        if (!dir_q) begin
                            rdata_d = OPEN_BUS;
                        end
                    end
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == ST_IDLE);
    assign done      = (state_q == ST_HOLD);
    assign port_rd_n = !((state_q == ST_STROBE) && !dir_q);
    assign port_wr_n = !((state_q == ST_STROBE) && dir_q);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign dev_dout  = dout_q;

    // Selects follow the latched address for the whole transaction, but a
    // bad address keeps every device deselected.
    assign sel_en = (state_q != ST_IDLE) && addr_valid(addr_q);

    io_port_decode u_dec_x (
        .en    (sel_en),
        .idx   (addr_q[ADDR_X_LSB +: ADDR_IDX_W]),
        .sel_n (sel_x)
    );

    io_port_decode u_dec_y (
        .en    (sel_en),
        .idx   (addr_q[ADDR_Y_LSB +: ADDR_IDX_W]),
        .sel_n (sel_y)
    );

endmodule

// File: tb/tb_io_sequencer.sv
// Randomized self-checking bench for io_sequencer against a transaction-level
// model of expected strobe length, completion time and result.
module tb_io_sequencer;

    localparam int WAIT_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       dir;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic       port_rd_n;
    logic       port_wr_n;
    logic [7:0] dev_dout;
    logic [7:0] dev_din;
    logic       dev_ack;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rdata_m = 8'h00;
    logic       err_m   = 1'b0;
    logic [7:0] dout_m  = 8'h00;

    io_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dir       (dir),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .sel_x     (sel_x),
        .sel_y     (sel_y),
        .port_rd_n (port_rd_n),
        .port_wr_n (port_wr_n),
        .dev_dout  (dev_dout),
        .dev_din   (dev_din),
        .dev_ack   (dev_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] onehotLow(input logic [2:0] i);
        logic [7:0] v;
        v    = 8'hFF;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, "_ready"}, 8'(ready), 8'h01);
        checkOutput({tag, "_done"},  8'(done),  8'h00);
        checkOutput({tag, "_err"},   8'(err),   8'h00);
        checkOutput({tag, "_rdata"}, rdata,     8'h00);
        checkOutput({tag, "_dout"},  dev_dout,  8'h00);
        checkOutput({tag, "_rd_n"},  8'(port_rd_n), 8'h01);
        checkOutput({tag, "_wr_n"},  8'(port_wr_n), 8'h01);
        checkOutput({tag, "_sel_x"}, sel_x,     8'hFF);
        checkOutput({tag, "_sel_y"}, sel_y,     8'hFF);
    endtask

    // ack_cycle: strobe cycle (1-based) on which the device acks; 0 = never.
    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic applyStimulus(input logic [7:0] a, input logic d, input logic [7:0] w,
                                 input logic [7:0] din, input int ack_cycle);
        logic       good;
        logic       acked;
        int         len;
        int         done_c;
        logic       new_err;
        logic [7:0] new_rdata;
        logic       busy;
        logic       strobe_on;
        logic [7:0] exp_sx;
        logic [7:0] exp_sy;
        good      = (a[7:6] == 2'b00);
        acked     = (ack_cycle >= 1) && (ack_cycle <= WAIT_MAX);
        len       = acked ? ack_cycle : WAIT_MAX;
        done_c    = good ? 2 + len : 2;
        new_err   = !good || !acked;
        new_rdata = d ? rdata_m : (new_err ? 8'hFF : din);

        checkOutput("ready_at_req", 8'(ready), 8'h01);
        req = 1'b1; addr = a; dir = d; wdata = w; dev_din = din; dev_ack = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            busy      = (c <= done_c);
            strobe_on = good && (c >= 2) && (c <= 1 + len);
            exp_sx    = (busy && good) ? onehotLow(a[2:0]) : 8'hFF;
            exp_sy    = (busy && good) ? onehotLow(a[5:3]) : 8'hFF;
            checkOutput("ready", 8'(ready), 8'(!busy));
            checkOutput("done",  8'(done),  8'(c == done_c));
            checkOutput("rd_n",  8'(port_rd_n), 8'(!(strobe_on && !d)));
            checkOutput("wr_n",  8'(port_wr_n), 8'(!(strobe_on && d)));
            checkOutput("sel_x", sel_x, exp_sx);
            checkOutput("sel_y", sel_y, exp_sy);
            checkOutput("err",   8'(err), 8'((c >= done_c) ? new_err : err_m));
            checkOutput("rdata", rdata, (c >= done_c) ? new_rdata : rdata_m);
            checkOutput("dev_dout", dev_dout, w);
            req     = (c < done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            dev_ack = (ack_cycle != 0) && (c == ack_cycle + 1);
            if (c < done_c && $urandom_range(0, 3) == 0) begin
                addr  = 8'($urandom);
                wdata = 8'($urandom);
                dir   = 1'($urandom_range(0, 1));
            end
        end
        err_m   = new_err;
        rdata_m = new_rdata;
        dout_m  = w;
        dev_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        rst = 1'b0; req = 1'b0; dir = 1'b0; addr = 8'h00; wdata = 8'h00;
        dev_din = 8'h00; dev_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleReset("por");
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(8'h0B, 1'b0, 8'h00, 8'h5A, 1);
        applyStimulus(8'h3F, 1'b1, 8'hC3, 8'h11, 3);
        applyStimulus(8'h12, 1'b0, 8'hAA, 8'h77, 0);
        applyStimulus(8'h40, 1'b0, 8'h55, 8'h33, 1);
        applyStimulus(8'h21, 1'b0, 8'h66, 8'hA5, WAIT_MAX);
        applyStimulus(8'h2C, 1'b0, 8'h01, 8'h3C, 2);
        applyStimulus(8'h05, 1'b1, 8'h99, 8'h00, 0);
        applyStimulus(8'hC7, 1'b1, 8'h44, 8'h00, 1);
        applyStimulus(8'h80, 1'b0, 8'h12, 8'h00, 1);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            ra[7:6] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus(ra, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          int'($urandom_range(0, WAIT_MAX + 2)));
        end

        // Reset during the second strobe cycle of an IN with no ack.
        req = 1'b1; addr = 8'h09; dir = 1'b0; wdata = 8'hE1; dev_din = 8'h42; dev_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        req = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checkOutput("mid_rd_n_low", 8'(port_rd_n), 8'h00);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        checkIdleReset("mid_rst");
        rst = 1'b1;
        rdata_m = 8'h00; err_m = 1'b0; dout_m = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("post_rst_done",  8'(done),  8'h00);
            checkOutput("post_rst_ready", 8'(ready), 8'h01);
        end
        applyStimulus(8'h1B, 1'b0, 8'h07, 8'hB4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
